// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer: per-button FSM encoding
// and synchronizer depth.
package btn_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      PRESS_WAIT   = 2'b01,
      PRESSED      = 2'b11,
      RELEASE_WAIT = 2'b10
   } btn_state_t;

   localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/btn_debounce_cell.sv
// One-button debouncer: 2-flop synchronizer, debounce FSM and counter.
// With BTN_AUTOREPEAT_EN defined, a held button re-pulses every REPEAT_CYCLES.
module btn_debounce_cell
   import btn_debounce_pkg::*;
#(
   parameter int unsigned NB_COUNTER      = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 100
`ifdef BTN_AUTOREPEAT_EN
   ,
   parameter int unsigned REPEAT_CYCLES   = 1000
`endif
) (
   input  logic clock,
   input  logic i_reset,
   input  logic i_btn,
   output logic o_btn_level,
   output logic o_btn_pulse
);

   localparam logic [NB_COUNTER-1:0] DB_LIMIT = NB_COUNTER'(DEBOUNCE_CYCLES - 1);
   localparam logic [NB_COUNTER-1:0] CNT_ONE  = NB_COUNTER'(1);

   logic [SYNC_DEPTH-1:0] sync;
   logic                  s;
   logic [NB_COUNTER-1:0] cnt;
   btn_state_t            state;

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [NB_COUNTER-1:0] RPT_LIMIT = NB_COUNTER'(REPEAT_CYCLES - 1);
   logic [NB_COUNTER-1:0] rpt_cnt;
`endif

   assign s = sync[SYNC_DEPTH-1];

   always_ff @(posedge clock) begin
      if (!i_reset) begin
         sync        <= '0;
         cnt         <= '0;
         state       <= IDLE;
         o_btn_level <= 1'b0;
         o_btn_pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rpt_cnt     <= '0;
`endif
      end else begin
         sync        <= {sync[SYNC_DEPTH-2:0], i_btn};
         o_btn_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == DB_LIMIT) begin
                  state       <= PRESSED;
                  o_btn_level <= 1'b1;
                  o_btn_pulse <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                  rpt_cnt     <= '0;
`endif
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            PRESSED: begin
               // Repeat counter restarts from 0 on exit so a bounce back from
               // RELEASE_WAIT resumes the full repeat period.
               if (!s) begin
                  state   <= RELEASE_WAIT;
                  cnt     <= '0;
`ifdef BTN_AUTOREPEAT_EN
                  rpt_cnt <= '0;
               end else if (rpt_cnt == RPT_LIMIT) begin
                  o_btn_pulse <= 1'b1;
                  rpt_cnt     <= '0;
               end else begin
                  rpt_cnt <= rpt_cnt + CNT_ONE;
`endif
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  state <= PRESSED;
               end else if (cnt == DB_LIMIT) begin
                  state       <= IDLE;
                  o_btn_level <= 1'b0;
                  cnt         <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/btn_debounce.sv
// Debounces NB_BTN raw push-buttons into clean levels and one-cycle press
// pulses. Optional autorepeat is enabled with BTN_AUTOREPEAT_EN.
module btn_debounce
   import btn_debounce_pkg::*;
#(
   parameter int unsigned NB_BTN          = 4,
   parameter int unsigned NB_COUNTER      = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 100,
   parameter int unsigned REPEAT_CYCLES   = 1000
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic [NB_BTN-1:0] i_btn,
   output logic [NB_BTN-1:0] o_btn_level,
   output logic [NB_BTN-1:0] o_btn_pulse
);

   localparam longint unsigned CNT_MAX = (64'(1) << NB_COUNTER) - 64'(1);

   if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) > CNT_MAX) begin : g_bad_debounce
      $error("btn_debounce: DEBOUNCE_CYCLES out of range for NB_COUNTER");
   end
   if (REPEAT_CYCLES < 1 || 64'(REPEAT_CYCLES) > CNT_MAX) begin : g_bad_repeat
      $error("btn_debounce: REPEAT_CYCLES out of range for NB_COUNTER");
   end

   for (genvar i = 0; i < NB_BTN; i++) begin : g_cell
      btn_debounce_cell #(
         .NB_COUNTER      (NB_COUNTER),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
         ,
         .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
      ) u_cell (
         .clock       (clock),
         .i_reset     (i_reset),
         .i_btn       (i_btn[i]),
         .o_btn_level (o_btn_level[i]),
         .o_btn_pulse (o_btn_pulse[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=8, REPEAT_CYCLES=20.
// Press-relative edge e: pulse at e=11 (plus every 20 after with autorepeat).
module tb_btn_debounce;

   localparam int unsigned DB  = 8;
   localparam int unsigned RPT = 20;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       i_reset;
   logic [3:0] i_btn;
   logic [3:0] o_btn_level;
   logic [3:0] o_btn_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   btn_debounce #(
      .NB_BTN          (4),
      .NB_COUNTER      (16),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_CYCLES   (RPT)
   ) dut (
      .clock       (clock),
      .i_reset     (i_reset),
      .i_btn       (i_btn),
      .o_btn_level (o_btn_level),
      .o_btn_pulse (o_btn_pulse)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance one edge, sample 1 ns later, check both outputs.
   task automatic cyc(input string tag, input logic [3:0] el, input logic [3:0] ep);
      @(posedge clock);
      #1;
      chk({tag, " level"}, o_btn_level, el);
      chk({tag, " pulse"}, o_btn_pulse, ep);
   endtask

   function automatic bit pulse_at(input int e);
      return (e == DB + 3) || (AR && e > DB + 3 && ((e - (DB + 3)) % RPT) == 0);
   endfunction

   task automatic press_hold(input string tag, input logic [3:0] mask, input int hold);
      i_btn = i_btn | mask;
      for (int e = 1; e <= hold; e++)
         cyc(tag, (e >= DB + 3) ? mask : 4'b0000, pulse_at(e) ? mask : 4'b0000);
   endtask

   // The FSM still sees the button high for two edges after the raw release.
   task automatic release_btn(input string tag, input logic [3:0] mask, input int hold);
      i_btn = i_btn & ~mask;
      for (int k = 1; k <= DB + 5; k++)
         cyc(tag, (k < DB + 3) ? mask : 4'b0000,
             (k <= 2 && pulse_at(hold + k)) ? mask : 4'b0000);
   endtask

   initial begin
      i_reset = 1'b0;
      i_btn   = 4'b1111;

      for (int k = 0; k < 4; k++) cyc("reset", 4'b0000, 4'b0000);
      i_btn   = 4'b0000;
      i_reset = 1'b1;
      for (int k = 0; k < 3; k++) cyc("idle", 4'b0000, 4'b0000);

      press_hold("clean_press", 4'b0010, 50);
      release_btn("clean_release", 4'b0010, 50);

      i_btn = 4'b0100;
      for (int k = 0; k < 5; k++) cyc("glitch_hi", 4'b0000, 4'b0000);
      i_btn = 4'b0000;
      for (int k = 0; k < 15; k++) cyc("glitch_lo", 4'b0000, 4'b0000);

      for (int seg = 0; seg < 10; seg++) begin
         i_btn[3] = (seg % 2 == 0);
         for (int k = 0; k < 3; k++) cyc("bounce", 4'b0000, 4'b0000);
      end
      press_hold("bounce_settle", 4'b1000, 15);
      release_btn("bounce_release", 4'b1000, 15);

      press_hold("simul_press", 4'b1001, 12);
      release_btn("simul_release", 4'b1001, 12);

      i_btn = 4'b0001;
      for (int k = 0; k < 7; k++) cyc("wait_pre_rst", 4'b0000, 4'b0000);
      i_reset = 1'b0;
      for (int k = 0; k < 2; k++) cyc("mid_wait_rst", 4'b0000, 4'b0000);
      i_reset = 1'b1;
      press_hold("held_thru_rst", 4'b0001, 12);
      release_btn("held_thru_rst_rel", 4'b0001, 12);

      press_hold("long_hold", 4'b0001, 70);
      release_btn("long_hold_rel", 4'b0001, 70);

      for (int k = 0; k < 3; k++) cyc("final_idle", 4'b0000, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
